// File: rtl/mem_access_unit_if.sv
// Request/response/data-memory bundle for mem_access_unit.
// The slave modport is the unit itself; master is the requester plus memory side.
interface mem_access_unit_if #(
    parameter int WORD     = 16,
    parameter int ADDRESSL = 10,
    parameter int DEPTH    = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                reqValid;
    logic                reqReady;
    logic                reqWrite;
    logic [ADDRESSL-1:0] reqAddress;
    logic [WORD-1:0]     reqData;
    logic                respValid;
    logic                respReady;
    logic [WORD-1:0]     respData;
    logic [ADDRESSL-1:0] address;
    logic [WORD-1:0]     writeData;
    logic                memRead;
    logic                memWrite;
    logic [WORD-1:0]     readData;
    logic [CW-1:0]       count;
    logic                busy;

    modport slave (
        input  reqValid, reqWrite, reqAddress, reqData, respReady, readData,
        output reqReady, respValid, respData, address, writeData,
        memRead, memWrite, count, busy
    );

    modport master (
        output reqValid, reqWrite, reqAddress, reqData, respReady, readData,
        input  reqReady, respValid, respData, address, writeData,
        memRead, memWrite, count, busy
    );
endinterface

// File: rtl/mem_access_unit.sv
// In-order load/store unit: request FIFO feeding an IDLE/ISSUE/CAPTURE/RESP
// sequencer that drives a data memory with a one-cycle registered read.
module mem_access_unit #(
    parameter int WORD     = 16,
    parameter int ADDRESSL = 10,
    parameter int DEPTH    = 4
) (
    input  logic               clk,
    input  logic               rst,
    mem_access_unit_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = 1 + ADDRESSL + WORD;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    logic [EW-1:0]       r_fifo [DEPTH];
    logic [PW-1:0]       r_wr_ptr;
    logic [PW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;
    state_t              r_state;
    logic                r_cmd_write;
    logic [ADDRESSL-1:0] r_cmd_addr;
    logic [WORD-1:0]     r_cmd_data;
    logic [WORD-1:0]     r_resp_data;
    logic                r_resp_valid;
    logic                r_mem_read;
    logic                r_mem_write;

    logic                w_ready;
    logic                w_push;
    logic                w_pop;
    logic [EW-1:0]       w_head;

    assign w_ready = (r_count < CW'(DEPTH));
    assign w_push  = bus.reqValid && w_ready;
    assign w_pop   = (r_state == IDLE) && (r_count != '0);
    assign w_head  = r_fifo[r_rd_ptr];

    // Head must be visible in the same cycle it is popped, so storage is read asynchronously.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {bus.reqWrite, bus.reqAddress, bus.reqData};
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally at their width.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_cmd_write  <= 1'b0;
            r_cmd_addr   <= '0;
            r_cmd_data   <= '0;
            r_resp_data  <= '0;
            r_resp_valid <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        {r_cmd_write, r_cmd_addr, r_cmd_data} <= w_head;
                        r_mem_write <= w_head[EW-1];
                        r_mem_read  <= !w_head[EW-1];
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                    r_state     <= r_cmd_write ? IDLE : CAPTURE;
                end
                CAPTURE: begin
                    r_resp_data  <= bus.readData;
                    r_resp_valid <= 1'b1;
                    r_state      <= RESP;
                end
                RESP: begin
                    if (bus.respReady) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Strobes are masked by reset directly so an in-flight ISSUE cannot touch memory.
    assign bus.memRead   = r_mem_read  && rst;
    assign bus.memWrite  = r_mem_write && rst;
    assign bus.address   = (r_state == ISSUE) ? r_cmd_addr : '0;
    assign bus.writeData = (r_state == ISSUE) ? r_cmd_data : '0;
    assign bus.reqReady  = w_ready;
    assign bus.respValid = r_resp_valid;
    assign bus.respData  = r_resp_data;
    assign bus.count     = r_count;
    assign bus.busy      = (r_count != '0) || (r_state != IDLE);
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table of isolated requests plus
// hand-written sequences for backpressure, wrap, stall, reset and push/pop overlap.
module tb_mem_access_unit;
    logic clk;
    logic rst;

    mem_access_unit_if #(.WORD(16), .ADDRESSL(10), .DEPTH(4)) bus ();

    mem_access_unit #(.WORD(16), .ADDRESSL(10), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory with one-cycle registered read.
    logic [15:0] mem [1024];
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    end
    always @(posedge clk) begin
        if (bus.memWrite) mem[bus.address] <= bus.writeData;
        if (bus.memRead)  bus.readData <= mem[bus.address];
    end

    int n_checks = 0;
    int n_err    = 0;

    logic [15:0] got_q [$];
    logic [15:0] exp_q [$];

    always @(negedge clk) begin
        if (rst && bus.respValid && bus.respReady) got_q.push_back(bus.respData);
    end

    typedef struct {
        logic        wr;
        logic [9:0]  addr;
        logic [15:0] data;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [8];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic set_req(input logic wr, input logic [9:0] a, input logic [15:0] d);
        bus.reqValid   = 1'b1;
        bus.reqWrite   = wr;
        bus.reqAddress = a;
        bus.reqData    = d;
    endtask

    // Single request into an idle unit, checking the exact cycle-by-cycle timing.
    task automatic do_req(input int idx, input logic wr, input logic [9:0] a,
                          input logic [15:0] d, input logic [15:0] exp);
        bus.respReady = 1'b0;
        set_req(wr, a, d);
        check($sformatf("v%0d_ready", idx), bus.reqReady, 1);
        tick;
        bus.reqValid = 1'b0;
        check($sformatf("v%0d_count_after_accept", idx), bus.count, 1);
        check($sformatf("v%0d_idle_strobes", idx), {bus.memRead, bus.memWrite}, 0);
        check($sformatf("v%0d_idle_addr", idx), bus.address, 0);
        tick;
        check($sformatf("v%0d_issue_addr", idx), bus.address, a);
        check($sformatf("v%0d_memWrite", idx), bus.memWrite, wr);
        check($sformatf("v%0d_memRead", idx), bus.memRead, !wr);
        if (wr) check($sformatf("v%0d_writeData", idx), bus.writeData, d);
        tick;
        check($sformatf("v%0d_strobes_off", idx), {bus.memRead, bus.memWrite}, 0);
        if (wr) begin
            check($sformatf("v%0d_mem", idx), mem[a], d);
            check($sformatf("v%0d_busy", idx), bus.busy, 0);
            $display("req %0d: store addr=0x%03h data=0x%04h", idx, a, d);
        end else begin
            check($sformatf("v%0d_respValid_early", idx), bus.respValid, 0);
            tick;
            check($sformatf("v%0d_respValid", idx), bus.respValid, 1);
            check($sformatf("v%0d_respData", idx), bus.respData, exp);
            bus.respReady = 1'b1;
            tick;
            bus.respReady = 1'b0;
            check($sformatf("v%0d_resp_done", idx), bus.respValid, 0);
            check($sformatf("v%0d_busy", idx), bus.busy, 0);
            $display("req %0d: load  addr=0x%03h resp=0x%04h", idx, a, bus.respData);
        end
    endtask

    task automatic push(input logic wr, input logic [9:0] a, input logic [15:0] d);
        int n;
        n = 0;
        set_req(wr, a, d);
        while (!bus.reqReady && n < 50) begin
            tick;
            n++;
        end
        check("push_wait_bound", (n < 50), 1);
        tick;
        bus.reqValid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        bus.respReady = 1'b1;
        while (bus.busy && n < 200) begin
            tick;
            n++;
        end
        check({nm, "_drain_bound"}, (n < 200), 1);
        check({nm, "_resp_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                check($sformatf("%s_resp%0d", nm, i), got_q[i], exp_q[i]);
                $display("%s: response %0d = 0x%04h", nm, i, got_q[i]);
            end
        end
        bus.respReady = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{wr: 1'b1, addr: 10'h005, data: 16'h1234, exp: 16'h0000};
        vecs[1] = '{wr: 1'b0, addr: 10'h005, data: 16'h0000, exp: 16'h1234};
        vecs[2] = '{wr: 1'b1, addr: 10'h3FF, data: 16'hBEEF, exp: 16'h0000};
        vecs[3] = '{wr: 1'b0, addr: 10'h3FF, data: 16'h0000, exp: 16'hBEEF};
        vecs[4] = '{wr: 1'b1, addr: 10'h000, data: 16'h5A5A, exp: 16'h0000};
        vecs[5] = '{wr: 1'b0, addr: 10'h000, data: 16'h0000, exp: 16'h5A5A};
        vecs[6] = '{wr: 1'b1, addr: 10'h005, data: 16'hFFFF, exp: 16'h0000};
        vecs[7] = '{wr: 1'b0, addr: 10'h005, data: 16'h0000, exp: 16'hFFFF};

        rst = 1'b0;
        bus.reqValid = 1'b0;
        bus.reqWrite = 1'b0;
        bus.reqAddress = '0;
        bus.reqData = '0;
        bus.respReady = 1'b0;
        tick;
        tick;
        check("reset_strobes", {bus.memRead, bus.memWrite}, 0);
        rst = 1'b1;
        check("reset_reqReady", bus.reqReady, 1);
        check("reset_respValid", bus.respValid, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_count", bus.count, 0);
        check("reset_respData", bus.respData, 0);
        check("reset_address", bus.address, 0);

        for (int i = 0; i < 8; i++) do_req(i, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].exp);

        // Backpressure: FSM stalled in RESP while the FIFO fills.
        got_q.delete();
        exp_q.delete();
        bus.respReady = 1'b0;
        set_req(1'b0, 10'h005, 16'h0000);
        tick;
        set_req(1'b1, 10'h010, 16'hA001); tick;
        set_req(1'b1, 10'h011, 16'hA002); tick;
        set_req(1'b1, 10'h012, 16'hA003); tick;
        set_req(1'b0, 10'h011, 16'h0000); tick;
        set_req(1'b0, 10'h010, 16'h0000);
        check("full_count", bus.count, 4);
        check("full_reqReady", bus.reqReady, 0);
        check("full_respValid", bus.respValid, 1);
        check("full_respData", bus.respData, 16'hFFFF);
        tick;
        tick;
        check("full_count_hold", bus.count, 4);
        bus.respReady = 1'b1;
        tick;
        bus.respReady = 1'b0;
        check("fifth_blocked_count", bus.count, 4);
        check("fifth_blocked_respValid", bus.respValid, 0);
        tick;
        check("after_pop_count", bus.count, 3);
        check("after_pop_reqReady", bus.reqReady, 1);
        tick;
        bus.reqValid = 1'b0;
        check("fifth_accepted_count", bus.count, 4);
        exp_q.push_back(16'hFFFF);
        exp_q.push_back(16'hA002);
        exp_q.push_back(16'hA001);
        drain("backpressure");

        // Long response stall, then push+pop overlap at count=2.
        got_q.delete();
        exp_q.delete();
        bus.respReady = 1'b0;
        set_req(1'b0, 10'h3FF, 16'h0000);
        tick;
        bus.reqValid = 1'b0;
        tick;
        tick;
        tick;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("stall%0d_respValid", k), bus.respValid, 1);
            check($sformatf("stall%0d_respData", k), bus.respData, 16'hBEEF);
            if (k == 5) set_req(1'b1, 10'h020, 16'hC001);
            tick;
        end
        set_req(1'b1, 10'h021, 16'hC002);
        bus.respReady = 1'b1;
        check("stall_last_respValid", bus.respValid, 1);
        tick;
        bus.respReady = 1'b0;
        check("stall_resp_done", bus.respValid, 0);
        check("pre_overlap_count", bus.count, 2);
        set_req(1'b0, 10'h020, 16'h0000);
        tick;
        bus.reqValid = 1'b0;
        check("push_pop_count", bus.count, 2);
        check("oldest_memWrite", bus.memWrite, 1);
        check("oldest_address", bus.address, 10'h020);
        check("oldest_writeData", bus.writeData, 16'hC001);
        exp_q.push_back(16'hBEEF);
        exp_q.push_back(16'hC001);
        drain("overlap");

        // Reset during a store's ISSUE cycle with three entries behind it.
        got_q.delete();
        exp_q.delete();
        bus.respReady = 1'b0;
        set_req(1'b0, 10'h005, 16'h0000); tick;
        set_req(1'b1, 10'h030, 16'hDEAD); tick;
        set_req(1'b1, 10'h031, 16'h0001); tick;
        set_req(1'b1, 10'h032, 16'h0002); tick;
        set_req(1'b0, 10'h030, 16'h0000); tick;
        bus.reqValid = 1'b0;
        bus.respReady = 1'b1;
        tick;
        bus.respReady = 1'b0;
        tick;
        check("pre_reset_memWrite", bus.memWrite, 1);
        check("pre_reset_count", bus.count, 3);
        rst = 1'b0;
        #1;
        check("rst_masks_memWrite", bus.memWrite, 0);
        check("rst_masks_memRead", bus.memRead, 0);
        tick;
        rst = 1'b1;
        check("post_rst_count", bus.count, 0);
        check("post_rst_busy", bus.busy, 0);
        check("post_rst_reqReady", bus.reqReady, 1);
        check("post_rst_respValid", bus.respValid, 0);
        check("post_rst_respData", bus.respData, 0);
        check("post_rst_mem_untouched", mem[10'h030], 16'h0000);
        tick;
        check("post_rst_idle_busy", bus.busy, 0);
        check("post_rst_idle_strobes", {bus.memRead, bus.memWrite}, 0);

        // Ten alternating store/load requests, wrapping the FIFO pointers.
        got_q.delete();
        exp_q.delete();
        bus.respReady = 1'b1;
        for (int i = 0; i < 10; i++) begin
            logic [9:0]  a;
            logic [15:0] d;
            a = ((i / 2) % 2 == 1) ? 10'h3FF : 10'h3FE;
            d = 16'h1000 + 16'((i / 2) * 16'h0111);
            if (i % 2 == 0) begin
                push(1'b1, a, d);
            end else begin
                push(1'b0, a, 16'h0000);
                exp_q.push_back(d);
            end
        end
        drain("wrap");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameters SHALL be: WORD, default 16, data width; ADDRESSL, default 10, address width; DEPTH, default 4, request FIFO entries (power of two).
REQ-002 clk  input  1  single clock; all state updates on the posedge.
REQ-003 rst  input  1  reset, synchronous and active-low.
REQ-004 reqValid  input  1  upstream request present.
REQ-005 reqReady  output  1  unit can accept a request this cycle.
REQ-006 reqWrite  input  1  1 = store, 0 = load.
REQ-007 reqAddress  input  ADDRESSL  word address.
REQ-008 reqData  input  WORD  store data, ignored for loads.
REQ-009 respValid  output  1  load result available.
REQ-010 respReady  input  1  consumer accepts the load result.
REQ-011 respData  output  WORD  load result.
REQ-012 address  output  ADDRESSL  to data memory.
REQ-013 writeData  output  WORD  to data memory.
REQ-014 memRead  output  1  to data memory, one-cycle strobe.
REQ-015 memWrite  output  1  to data memory, one-cycle strobe.
REQ-016 readData  input  WORD  from data memory; registered, valid the cycle after the memRead edge.
REQ-017 count  output  clog2(DEPTH)+1  current FIFO occupancy.
REQ-018 busy  output  1  high when the FIFO is non-empty or the FSM is not IDLE.

Function
REQ-019 A request SHALL be accepted on a posedge with reqValid && reqReady, pushing {reqWrite, reqAddress, reqData} into an in-order FIFO.
REQ-020 reqReady SHALL equal (count < DEPTH), combinational from registered count only.
REQ-021 A push and a pop in the same cycle SHALL leave count unchanged. A full FIFO SHALL never be pushed. An empty FIFO SHALL never be popped.
REQ-022 FIFO pointers SHALL wrap modulo DEPTH, with no data loss across the wrap.
REQ-023 FSM states SHALL be IDLE, ISSUE, CAPTURE and RESP.
REQ-024 IDLE: if count > 0, pop the head into the command register and go to ISSUE; otherwise stay in IDLE.
REQ-025 ISSUE: for exactly one cycle, drive address/writeData from the command register and assert memWrite (store) or memRead (load). A store then goes to IDLE; a load goes to CAPTURE.
REQ-026 CAPTURE: latch readData into respData and go to RESP.
REQ-027 RESP: hold respValid=1 and keep respData stable until respValid && respReady at a posedge, then go to IDLE.
REQ-028 The FIFO SHALL keep accepting requests while the FSM is in ISSUE, CAPTURE or RESP.
REQ-029 memRead and memWrite SHALL never both be high, and SHALL be low outside ISSUE.
REQ-030 address and writeData SHALL be 0 outside ISSUE.
REQ-031 Load latency SHALL be: request accepted at edge N into an empty FIFO with the FSM in IDLE -> memRead high in the cycle after N+1 -> respValid high after edge N+3.
REQ-032 Store issue latency SHALL be: memWrite high in the cycle after N+1; the memory is updated at edge N+2.
REQ-033 Requests SHALL complete strictly in acceptance order, so a load after a store to the same address returns the stored value.

Reset
REQ-034 While rst=0 at a posedge, the unit SHALL clear FIFO pointers and count to 0, set state to IDLE, and clear respData and the command register to 0.
REQ-035 While rst=0, memRead and memWrite SHALL be forced to 0 combinationally, including during an in-flight ISSUE cycle.
REQ-036 After reset: reqReady=1, respValid=0, busy=0, count=0. Queued and in-flight requests are discarded with no response.

Verification
REQ-037 Store 0x1234 to address 0x005, then load address 0x005 -> memWrite at address 5 with writeData 0x1234, then memRead at address 5; respData=0x1234 with respValid high 3 cycles after the load is accepted.
REQ-038 Push 5 requests back-to-back with the FSM stalled in RESP (respReady=0) -> count reaches 4, reqReady=0 on the 5th request, count stays 4, and the 5th request is not accepted until respReady=1.
REQ-039 Issue 10 alternating store/load requests to addresses 0x3FE/0x3FF -> pointers wrap past DEPTH, and all loads return their matching store data in order.
REQ-040 Hold respReady=0 for 6 cycles on a load returning 0xBEEF -> respValid and respData=0xBEEF are stable for all 6 cycles, and the response completes on the first respReady=1 edge.
REQ-041 Assert rst=0 during the ISSUE cycle of a store with 3 entries queued -> memWrite=0 in that cycle, and the next cycle shows count=0, busy=0, reqReady=1, respValid=0.
REQ-042 Apply simultaneous push and pop with count=2 -> count stays 2, and the popped command is the oldest entry.
